// File: rtl/i2c_slave_write_bit.sv
// Slave-side single-bit I2C transmitter: presents one bit on open-drain SDA
// across one SCL high phase and pulses finish after the master's rising edge.
module i2c_slave_write_bit (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic data,
    input  logic scl,
    output logic finish,
    output logic sda
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_d;
    logic   bit_q, bit_d;
    logic   drive_low, drive_d;
    logic   finish_d;
    logic   scl_last;
    logic   rise, fall;

    assign rise = ~scl_last & scl;
    assign fall = scl_last & ~scl;

    // Open-drain pad: only ever pull low, otherwise release to the pull-up.
    assign sda = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_q     <= 1'b1;
            drive_low <= 1'b0;
            finish    <= 1'b0;
            scl_last  <= 1'b1;
        end else begin
            state     <= state_d;
            bit_q     <= bit_d;
            drive_low <= drive_d;
            finish    <= finish_d;
            scl_last  <= scl;
        end
    end

    // SDA may only change while SCL is low, so every drive update is gated on ~scl.
    always_comb begin
        state_d  = state;
        bit_d    = bit_q;
        drive_d  = drive_low;
        finish_d = 1'b0;
        unique case (state)
            IDLE: begin
                drive_d = 1'b0;
                if (enable) begin
                    bit_d   = data;
                    state_d = DRIVE;
                    if (!scl) begin
                        drive_d = ~data;
                    end
                end
            end
            DRIVE: begin
                if (!scl) begin
                    drive_d = ~bit_q;
                end
                if (rise) begin
                    finish_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (fall) begin
                    drive_d = 1'b0;
                    state_d = IDLE;
                    if (enable) begin
                        bit_d   = data;
                        drive_d = ~data;
                        state_d = DRIVE;
                    end
                end
            end
            default: begin
                drive_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_write_bit.sv
// Directed bench for i2c_slave_write_bit: SCL = clock/8, pull-up on SDA,
// expected bits queued at enable and checked when finish pulses.
module tb_i2c_slave_write_bit;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic data;
    logic scl;
    logic finish;
    wire  sda_w;

    pullup (sda_w);

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    i2c_slave_write_bit dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .data   (data),
        .scl    (scl),
        .finish (finish),
        .sda    (sda_w)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One SCL period (4 clocks low, 4 high); inputs change on the falling clock edge.
    task automatic bit_period(input logic en, input logic d, input logic rst_mid,
                              input logic busy_en);
        logic exp_sda;
        logic exp_fin;
        logic popped;
        exp_sda = (en && !rst_mid) ? d : 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                check("sda_released_after_fall", sda_w, 1'b1);
                check("finish_idle_low", finish, 1'b0);
            end
            if (k >= 2) begin
                exp_fin = (k == 5) && en && !rst_mid;
                check($sformatf("finish_k%0d", k), finish, exp_fin);
                if (!(rst_mid && k == 2)) begin
                    check($sformatf("sda_k%0d", k), sda_w, exp_sda);
                end else begin
                    check("sda_before_reset", sda_w, d);
                end
                if (finish) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 1'b1, 1'b0);
                    end else begin
                        popped = exp_q.pop_front();
                        check("sda_at_finish", sda_w, popped);
                    end
                end
            end
            case (k)
                0: scl = 1'b0;
                1: begin
                    enable = en;
                    data   = d;
                    if (en) exp_q.push_back(d);
                end
                2: begin
                    enable = 1'b0;
                    if (rst_mid) begin
                        reset = 1'b1;
                        if (en) void'(exp_q.pop_back());
                        #1;
                        check("sda_on_reset", sda_w, 1'b1);
                        check("finish_on_reset", finish, 1'b0);
                    end
                end
                3: begin
                    reset = 1'b0;
                    data  = ~d;
                end
                4: scl = 1'b1;
                5: data = d;
                6: if (busy_en) begin
                    enable = 1'b1;
                    data   = ~d;
                end
                7: enable = 1'b0;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [31:0] word;
        word   = 32'h13579BDF;
        reset  = 1'b1;
        enable = 1'b0;
        data   = 1'b0;
        scl    = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_sda", sda_w, 1'b1);
        check("reset_finish", finish, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Full 32-bit stream, MSB first.
        for (int i = 31; i >= 0; i--) begin
            bit_period(1'b1, word[i], 1'b0, 1'b0);
        end

        // Single zero, single one.
        bit_period(1'b1, 1'b0, 1'b0, 1'b0);
        bit_period(1'b1, 1'b1, 1'b0, 1'b0);

        // Idle periods: nothing driven, no finish.
        for (int i = 0; i < 3; i++) begin
            bit_period(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset while driving a zero, then a normal bit.
        bit_period(1'b1, 1'b0, 1'b1, 1'b0);
        bit_period(1'b1, 1'b0, 1'b0, 1'b0);

        // Data toggling plus an ignored enable while busy.
        bit_period(1'b1, 1'b0, 1'b0, 1'b1);
        bit_period(1'b1, 1'b1, 1'b0, 1'b1);

        @(negedge clock);
        scl = 1'b0;
        repeat (2) @(negedge clock);
        check("final_release", sda_w, 1'b1);
        check("scoreboard_drained", exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
